// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : PC owner and instruction fetch queue feeding decode over valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
   parameter int              PC_W     = 16,
   parameter int              INSTR_W  = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 2
) (
   input  logic               clk,
   input  logic               reset,
   output logic [PC_W-1:0]    pcout,
   input  logic [INSTR_W-1:0] instruction,
   input  logic               fetch_en,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [PC_W-1:0]    if_pc,
   input  logic               if_ready
);

   localparam int              c_ptr_w      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int              c_cnt_w      = $clog2(DEPTH + 1) + 1;
   localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
   localparam logic [c_ptr_w-1:0] c_last    = c_ptr_w'(DEPTH - 1);
   localparam logic [PC_W-1:0]    c_align   = ~PC_W'(1);
   localparam logic [PC_W-1:0]    c_step    = PC_W'(2);

   typedef enum logic [0:0] {
      S_RUN   = 1'b0,
      S_STALL = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [PC_W-1:0]      r_fetch_pc;
   logic [PC_W-1:0]      r_req_pc;
   logic                 r_inflight;
   logic [c_ptr_w-1:0]   r_head;
   logic [c_ptr_w-1:0]   r_tail;
   logic [c_cnt_w-1:0]   r_count;
   logic [PC_W-1:0]      r_last_pc;
   logic [INSTR_W-1:0]   r_last_instr;
   logic [PC_W-1:0]      r_q_pc    [DEPTH];
   logic [INSTR_W-1:0]   r_q_instr [DEPTH];

   logic                 w_pop;
   logic                 w_push;
   logic                 w_issue;
   logic [c_cnt_w-1:0]   w_occ;

   function automatic logic [c_ptr_w-1:0] f_next(input logic [c_ptr_w-1:0] p);
      return (p == c_last) ? '0 : p + c_ptr_w'(1);
   endfunction

   // Occupancy counts the in-flight read as already holding a slot, so a
   // return can always be pushed without an overflow check.
   assign w_occ   = r_count + c_cnt_w'(r_inflight) - c_cnt_w'(w_pop);
   assign w_pop   = if_valid & if_ready & ~redirect_valid;
   assign w_push  = r_inflight & ~redirect_valid;
   assign w_issue = (r_state == S_RUN) & ~redirect_valid & (w_occ < c_depth);

   assign pcout    = r_fetch_pc;
   assign if_valid = (r_count != '0);
   assign if_pc    = if_valid ? r_q_pc[r_head]    : r_last_pc;
   assign if_instr = if_valid ? r_q_instr[r_head] : r_last_instr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RUN:   if (!fetch_en) w_state_nxt = S_STALL;
         S_STALL: if (fetch_en)  w_state_nxt = S_RUN;
         default: w_state_nxt = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= '0;
         r_inflight <= 1'b0;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
      end else if (redirect_valid) begin
         r_fetch_pc <= redirect_pc & c_align;
         r_inflight <= 1'b0;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + c_step;
         end
         if (w_push) r_tail <= f_next(r_tail);
         if (w_pop)  r_head <= f_next(r_head);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_pc[r_tail]    <= r_req_pc;
         r_q_instr[r_tail] <= instruction;
      end
   end

   // Remember the head currently shown so the outputs hold it once the queue drains.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_pc    <= '0;
         r_last_instr <= '0;
      end else if (if_valid) begin
         r_last_pc    <= r_q_pc[r_head];
         r_last_instr <= r_q_instr[r_head];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed self-checking bench for fetch_unit with a mem[a]=a^A5A5 model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] pcout;
   logic [15:0] instruction = 16'h0000;
   logic        fetch_en;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic        if_ready;

   int checks = 0;
   int errors = 0;

   fetch_unit #(
      .PC_W     (16),
      .INSTR_W  (16),
      .RESET_PC (16'h0000),
      .DEPTH    (2)
   ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .pcout          (pcout),
      .instruction    (instruction),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_ready       (if_ready)
   );

   always #5 clk = ~clk;

   // Synchronous instruction memory: data for pcout appears the following cycle.
   always @(posedge clk) instruction <= pcout ^ 16'hA5A5;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic exp_head(input string tag, input logic [15:0] pc);
      chk({tag, " valid"}, {15'd0, if_valid}, 16'h0001);
      chk({tag, " pc"},    if_pc,    pc);
      chk({tag, " instr"}, if_instr, pc ^ 16'hA5A5);
   endtask

   initial begin
      logic [15:0] p;
      reset          = 1'b1;
      fetch_en       = 1'b1;
      if_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      tick();
      tick();
      reset = 1'b0;

      // Stream
      chk("rst valid", {15'd0, if_valid}, 16'h0000);
      chk("rst pcout", pcout, 16'h0000);
      chk("rst if_pc", if_pc, 16'h0000);
      chk("rst if_instr", if_instr, 16'h0000);
      tick();
      chk("c1 valid", {15'd0, if_valid}, 16'h0000);
      chk("c1 pcout", pcout, 16'h0002);
      tick();
      for (int k = 0; k < 6; k++) begin
         exp_head($sformatf("stream%0d", k), 16'(2 * k));
         chk($sformatf("stream%0d pcout", k), pcout, 16'(2 * k + 4));
         tick();
      end

      // Backpressure: head 000C held with 000E queued behind it
      if_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_head($sformatf("bp hold%0d", i), 16'h000C);
         chk($sformatf("bp pcout%0d", i), pcout, 16'h0010);
      end
      if_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_head($sformatf("bp resume%0d", i), 16'(16'h000E + 2 * i));
      end

      // Redirect while full
      if_ready = 1'b0;
      tick();
      exp_head("full head", 16'h0012);
      chk("full pcout", pcout, 16'h0016);
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0041;
      if_ready       = 1'b1;
      tick();
      redirect_valid = 1'b0;
      chk("rd c1 valid", {15'd0, if_valid}, 16'h0000);
      chk("rd c1 pcout", pcout, 16'h0040);
      chk("rd c1 hold pc", if_pc, 16'h0012);
      tick();
      chk("rd c2 valid", {15'd0, if_valid}, 16'h0000);
      chk("rd c2 pcout", pcout, 16'h0042);
      tick();
      exp_head("rd first", 16'h0040);
      tick();
      exp_head("rd second", 16'h0042);

      // Wrap, redirecting while a fetch of 0044 is in flight
      redirect_valid = 1'b1;
      redirect_pc    = 16'hFFFC;
      tick();
      redirect_valid = 1'b0;
      chk("wr c1 valid", {15'd0, if_valid}, 16'h0000);
      chk("wr c1 pcout", pcout, 16'hFFFC);
      tick();
      chk("wr c2 valid", {15'd0, if_valid}, 16'h0000);
      p = 16'hFFFC;
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_head($sformatf("wrap%0d", i), p);
         chk($sformatf("wrap%0d pcout", i), pcout, 16'(2 * i));
         p = p + 16'h0002;
      end

      // Stall: 0006 is issued this cycle while fetch_en drops
      fetch_en = 1'b0;
      tick();
      exp_head("st 0004", 16'h0004);
      chk("st pcout a", pcout, 16'h0008);
      tick();
      exp_head("st 0006", 16'h0006);
      chk("st pcout b", pcout, 16'h0008);
      tick();
      chk("st empty valid", {15'd0, if_valid}, 16'h0000);
      chk("st empty hold", if_pc, 16'h0006);
      chk("st pcout c", pcout, 16'h0008);
      tick();
      chk("st pcout d", pcout, 16'h0008);
      fetch_en = 1'b1;
      tick();
      chk("st resume pcout", pcout, 16'h0008);
      chk("st resume valid", {15'd0, if_valid}, 16'h0000);
      tick();
      chk("st resume pcout2", pcout, 16'h000A);
      tick();
      exp_head("st 0008", 16'h0008);

      // Reset mid-stream with a non-empty queue and a read in flight
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mr valid", {15'd0, if_valid}, 16'h0000);
      chk("mr pcout", pcout, 16'h0000);
      chk("mr if_pc", if_pc, 16'h0000);
      chk("mr if_instr", if_instr, 16'h0000);
      tick();
      chk("mr c1 valid", {15'd0, if_valid}, 16'h0000);
      chk("mr c1 pcout", pcout, 16'h0002);
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_head($sformatf("restart%0d", i), 16'(2 * i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
